// File: rtl/gift_ks_pkg.sv
// Shared op-codes, FSM states and round-key helpers for the GIFT key schedule.
// Optional SEEK support is compiled in with GIFT_KS_SEEK_EN.
package gift_ks_pkg;

    localparam logic [1:0] OpLoad = 2'b00;
    localparam logic [1:0] OpStep = 2'b01;
    localparam logic [1:0] OpSeek = 2'b10;

    localparam int unsigned RotHi = 2;
    localparam int unsigned RotLo = 12;

`ifdef GIFT_KS_SEEK_EN
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StOut  = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOut  = 2'd2
    } state_e;
`endif

    function automatic logic [15:0] rotr16(input logic [15:0] x, input int unsigned n);
        return (x >> n) | (x << (16 - n));
    endfunction

    function automatic logic [15:0] rotl16(input logic [15:0] x, input int unsigned n);
        return (x << n) | (x >> (16 - n));
    endfunction

    // GIFT-128 takes {k5,k4,k1,k0}; GIFT-64 only uses {k1,k0}.
    function automatic logic [63:0] rk_extract(input logic [127:0] k, input logic gift64);
        if (gift64) begin
            return {32'h0, k[31:0]};
        end
        return {k[95:64], k[31:0]};
    endfunction

endpackage

// File: rtl/gift_ks_step.sv
// One combinational GIFT key-update step; dir=1 undoes the forward step.
module gift_ks_step
    import gift_ks_pkg::*;
(
    input  logic         dir,
    input  logic [127:0] key_cur,
    output logic [127:0] key_nxt
);

    always_comb begin
        if (dir) begin
            key_nxt = {key_cur[95:0],
                       rotl16(key_cur[127:112], RotHi),
                       rotl16(key_cur[111:96], RotLo)};
        end else begin
            key_nxt = {rotr16(key_cur[31:16], RotHi),
                       rotr16(key_cur[15:0], RotLo),
                       key_cur[127:32]};
        end
    end

endmodule

// File: rtl/gift_keysch_engine.sv
// GIFT key-schedule engine: LOAD/STEP commands, plus multi-round SEEK when
// GIFT_KS_SEEK_EN is defined. Round keys leave over a valid/ready handshake.
module gift_keysch_engine
    import gift_ks_pkg::*;
#(
    parameter int unsigned ROUNDS = 40,
    parameter int unsigned UNROLL = 1,
    parameter int unsigned GIFT64 = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic         cmd_dir,
    input  logic [127:0] key_in,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [63:0]  rk_data,
    output logic [5:0]   round_idx,
    output logic [127:0] key_state,
    output logic         err
);

    localparam logic [5:0] IdxLast = 6'(ROUNDS - 1);

    state_e       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [5:0]   idx_q, idx_d;
    logic [63:0]  rk_data_q, rk_data_d;
    logic         err_q, err_d;

    logic         step_dir;
    logic [127:0] key_one;

`ifdef GIFT_KS_SEEK_EN
    logic         dir_q, dir_d;
    logic [127:0] chain [UNROLL+1];
    int unsigned  seek_rem;
    int unsigned  seek_n;
    logic [127:0] key_seek;

    // A running SEEK keeps its direction; otherwise the command's direction applies.
    assign step_dir = (state_q == StBusy) ? dir_q : cmd_dir;
    assign chain[0] = key_q;

    for (genvar i = 0; i < UNROLL; i++) begin : g_chain
        gift_ks_step u_step (
            .dir    (step_dir),
            .key_cur(chain[i]),
            .key_nxt(chain[i+1])
        );
    end

    assign key_one = chain[1];

    always_comb begin
        seek_rem = step_dir ? 32'(idx_q) : 32'(IdxLast) - 32'(idx_q);
        seek_n   = (seek_rem > UNROLL) ? UNROLL : seek_rem;
        key_seek = key_q;
        for (int unsigned i = 1; i <= UNROLL; i++) begin
            if (seek_n == i) begin
                key_seek = chain[i];
            end
        end
    end
`else
    assign step_dir = cmd_dir;

    gift_ks_step u_step (
        .dir    (step_dir),
        .key_cur(key_q),
        .key_nxt(key_one)
    );
`endif

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        idx_d     = idx_q;
        rk_data_d = rk_data_q;
        err_d     = 1'b0;
`ifdef GIFT_KS_SEEK_EN
        dir_d     = dir_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    unique case (cmd_op)
                        OpLoad: begin
                            key_d   = key_in;
                            idx_d   = '0;
                            state_d = StOut;
                        end
                        OpStep: begin
                            if (cmd_dir ? (idx_q != 6'd0) : (idx_q < IdxLast)) begin
                                key_d   = key_one;
                                idx_d   = cmd_dir ? idx_q - 6'd1 : idx_q + 6'd1;
                                state_d = StOut;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
`ifdef GIFT_KS_SEEK_EN
                        OpSeek: begin
                            dir_d   = cmd_dir;
                            state_d = (seek_rem == 0) ? StOut : StBusy;
                        end
`endif
                        default: err_d = 1'b1;
                    endcase
                end
            end
`ifdef GIFT_KS_SEEK_EN
            StBusy: begin
                key_d = key_seek;
                idx_d = dir_q ? idx_q - 6'(seek_n) : idx_q + 6'(seek_n);
                if (seek_rem == seek_n) begin
                    state_d = StOut;
                end
            end
`endif
            StOut: begin
                if (rk_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Round key is captured once on entry to OUT and held until consumed.
        if (state_d == StOut && state_q != StOut) begin
            rk_data_d = rk_extract(key_d, GIFT64 != 0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            key_q     <= '0;
            idx_q     <= '0;
            rk_data_q <= '0;
            err_q     <= 1'b0;
`ifdef GIFT_KS_SEEK_EN
            dir_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            idx_q     <= idx_d;
            rk_data_q <= rk_data_d;
            err_q     <= err_d;
`ifdef GIFT_KS_SEEK_EN
            dir_q     <= dir_d;
`endif
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign rk_valid  = (state_q == StOut);
    assign rk_data   = rk_data_q;
    assign round_idx = idx_q;
    assign key_state = key_q;
    assign err       = err_q;

endmodule

// File: tb/tb_gift_keysch_engine.sv
// Randomised self-checking bench for gift_keysch_engine (GIFT-128 and GIFT-64 instances).
module tb_gift_keysch_engine;

    localparam int A_ROUNDS = 40;
    localparam int A_UNROLL = 4;
    localparam int B_ROUNDS = 28;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         a_cmd_valid, a_cmd_ready, a_cmd_dir, a_rk_valid, a_rk_ready, a_err;
    logic [1:0]   a_cmd_op;
    logic [127:0] a_key_in, a_key_state;
    logic [63:0]  a_rk_data;
    logic [5:0]   a_round_idx;

    logic         b_cmd_valid, b_cmd_ready, b_cmd_dir, b_rk_valid, b_rk_ready, b_err;
    logic [1:0]   b_cmd_op;
    logic [127:0] b_key_in, b_key_state;
    logic [63:0]  b_rk_data;
    logic [5:0]   b_round_idx;

    int errors = 0;
    int checks = 0;

    logic [127:0] m_key;
    int           m_idx;

    gift_keysch_engine #(.ROUNDS(A_ROUNDS), .UNROLL(A_UNROLL), .GIFT64(0)) u_dut_a (
        .clk(clk), .rst(rst), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
        .cmd_op(a_cmd_op), .cmd_dir(a_cmd_dir), .key_in(a_key_in), .rk_valid(a_rk_valid),
        .rk_ready(a_rk_ready), .rk_data(a_rk_data), .round_idx(a_round_idx),
        .key_state(a_key_state), .err(a_err)
    );

    gift_keysch_engine #(.ROUNDS(B_ROUNDS), .UNROLL(3), .GIFT64(1)) u_dut_b (
        .clk(clk), .rst(rst), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_op(b_cmd_op), .cmd_dir(b_cmd_dir), .key_in(b_key_in), .rk_valid(b_rk_valid),
        .rk_ready(b_rk_ready), .rk_data(b_rk_data), .round_idx(b_round_idx),
        .key_state(b_key_state), .err(b_err)
    );

    // Reference model on 16-bit words, w[0] = k0.
    function automatic logic [15:0] m_ror(input logic [15:0] x, input int n);
        logic [31:0] d;
        d = {x, x};
        d = d >> n;
        return d[15:0];
    endfunction

    function automatic logic [127:0] m_fwd(input logic [127:0] k);
        logic [15:0] w [8];
        logic [15:0] n [8];
        logic [127:0] r;
        for (int i = 0; i < 8; i++) w[i] = k[16*i +: 16];
        for (int i = 0; i < 6; i++) n[i] = w[i+2];
        n[6] = m_ror(w[0], 12);
        n[7] = m_ror(w[1], 2);
        for (int i = 0; i < 8; i++) r[16*i +: 16] = n[i];
        return r;
    endfunction

    function automatic logic [127:0] m_inv(input logic [127:0] k);
        logic [15:0] w [8];
        logic [15:0] n [8];
        logic [127:0] r;
        for (int i = 0; i < 8; i++) w[i] = k[16*i +: 16];
        for (int i = 0; i < 6; i++) n[i+2] = w[i];
        n[1] = m_ror(w[7], 16 - 2);
        n[0] = m_ror(w[6], 16 - 12);
        for (int i = 0; i < 8; i++) r[16*i +: 16] = n[i];
        return r;
    endfunction

    function automatic logic [63:0] m_rk(input logic [127:0] k, input bit g64);
        if (g64) return {32'h0, k[31:16], k[15:0]};
        return {k[95:80], k[79:64], k[31:16], k[15:0]};
    endfunction

    function automatic logic [127:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic a_issue(input logic [1:0] op, input logic dir, input logic [127:0] k);
        checks++;
        if (a_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL a_issue_ready: cmd_ready=%0b want 1", a_cmd_ready);
        end
        a_cmd_valid = 1'b1;
        a_cmd_op    = op;
        a_cmd_dir   = dir;
        a_key_in    = k;
        @(posedge clk);
        #1;
        a_cmd_valid = 1'b0;
        a_key_in    = rand_key();
    endtask

    task automatic b_issue(input logic [1:0] op, input logic dir, input logic [127:0] k);
        checks++;
        if (b_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL b_issue_ready: cmd_ready=%0b want 1", b_cmd_ready);
        end
        b_cmd_valid = 1'b1;
        b_cmd_op    = op;
        b_cmd_dir   = dir;
        b_key_in    = k;
        @(posedge clk);
        #1;
        b_cmd_valid = 1'b0;
        b_key_in    = rand_key();
    endtask

    // Cycles from accept edge until rk_valid, counted so that rk_valid right after the edge is 1.
    task automatic a_wait_rk(output int n);
        n = 1;
        while (a_rk_valid !== 1'b1 && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic a_consume();
        a_rk_ready = 1'b1;
        @(posedge clk);
        #1;
        a_rk_ready = 1'b0;
    endtask

    task automatic b_consume();
        b_rk_ready = 1'b1;
        @(posedge clk);
        #1;
        b_rk_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (a_cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %0b want 1", a_cmd_ready); end
        checks++; if (a_rk_valid !== 1'b0) begin errors++; $display("FAIL reset_rk_valid: got %0b want 0", a_rk_valid); end
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", a_err); end
        checks++; if (a_rk_data !== 64'h0) begin errors++; $display("FAIL reset_rk_data: got %h want 0", a_rk_data); end
        checks++; if (a_round_idx !== 6'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", a_round_idx); end
        checks++; if (a_key_state !== 128'h0) begin errors++; $display("FAIL reset_key: got %h want 0", a_key_state); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (a_cmd_ready !== 1'b1 || a_rk_valid !== 1'b0) begin errors++; $display("FAIL reset_idle: ready=%0b valid=%0b want 1/0", a_cmd_ready, a_rk_valid); end
        m_key = '0;
        m_idx = 0;
    endtask

    task automatic test_load();
        a_rk_ready = 1'b1;
        a_issue(2'b00, 1'b0, 128'h1);
        a_rk_ready = 1'b1;
        checks++; if (a_rk_valid !== 1'b1) begin errors++; $display("FAIL load_valid: got %0b want 1", a_rk_valid); end
        checks++; if (a_rk_data !== 64'h1) begin errors++; $display("FAIL load_rk: got %h want 1", a_rk_data); end
        checks++; if (a_round_idx !== 6'd0) begin errors++; $display("FAIL load_idx: got %0d want 0", a_round_idx); end
        checks++; if (a_cmd_ready !== 1'b0) begin errors++; $display("FAIL load_busy_ready: got %0b want 0", a_cmd_ready); end
        @(posedge clk);
        #1;
        a_rk_ready = 1'b0;
        checks++; if (a_cmd_ready !== 1'b1 || a_rk_valid !== 1'b0) begin errors++; $display("FAIL load_release: ready=%0b valid=%0b want 1/0", a_cmd_ready, a_rk_valid); end
        m_key = 128'h1;
        m_idx = 0;
    endtask

    task automatic test_step();
        int n;
        a_issue(2'b01, 1'b0, rand_key());
        a_wait_rk(n);
        m_key = m_fwd(m_key);
        m_idx = 1;
        checks++; if (n != 1) begin errors++; $display("FAIL step_fwd_lat: got %0d want 1", n); end
        checks++; if (a_key_state !== 128'h0000_0010_0000_0000_0000_0000_0000_0000) begin errors++; $display("FAIL step_fwd_key: got %h", a_key_state); end
        checks++; if (a_key_state !== m_key) begin errors++; $display("FAIL step_fwd_model: got %h want %h", a_key_state, m_key); end
        checks++; if (a_round_idx !== 6'd1) begin errors++; $display("FAIL step_fwd_idx: got %0d want 1", a_round_idx); end
        a_consume();
        a_issue(2'b01, 1'b1, rand_key());
        a_wait_rk(n);
        m_key = 128'h1;
        m_idx = 0;
        checks++; if (n != 1) begin errors++; $display("FAIL step_inv_lat: got %0d want 1", n); end
        checks++; if (a_key_state !== 128'h1) begin errors++; $display("FAIL step_inv_key: got %h want 1", a_key_state); end
        checks++; if (a_round_idx !== 6'd0) begin errors++; $display("FAIL step_inv_idx: got %0d want 0", a_round_idx); end
        a_consume();
    endtask

    task automatic test_reject();
        logic [1:0] ops [3];
        logic       dirs [3];
        ops[0] = 2'b01; dirs[0] = 1'b1;
        ops[1] = 2'b11; dirs[1] = 1'b0;
        ops[2] = 2'b11; dirs[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_issue(ops[i], dirs[i], rand_key());
            checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL reject_err_%0d: got %0b want 1", i, a_err); end
            checks++; if (a_rk_valid !== 1'b0) begin errors++; $display("FAIL reject_valid_%0d: got %0b want 0", i, a_rk_valid); end
            checks++; if (a_cmd_ready !== 1'b1) begin errors++; $display("FAIL reject_ready_%0d: got %0b want 1", i, a_cmd_ready); end
            checks++; if (a_key_state !== m_key || a_round_idx !== 6'(m_idx)) begin errors++; $display("FAIL reject_state_%0d: key %h idx %0d want %h %0d", i, a_key_state, a_round_idx, m_key, m_idx); end
            @(posedge clk);
            #1;
            checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL reject_pulse_%0d: got %0b want 0", i, a_err); end
        end
    endtask

    task automatic test_walk();
        int n;
        logic dir;
        bit legal;
        m_key = rand_key();
        a_issue(2'b00, 1'b0, m_key);
        a_consume();
        m_idx = 0;
        for (int s = 0; s < A_ROUNDS - 1; s++) begin
            a_issue(2'b01, 1'b0, rand_key());
            a_wait_rk(n);
            m_key = m_fwd(m_key);
            m_idx++;
            checks++; if (n != 1 || a_key_state !== m_key || a_round_idx !== 6'(m_idx)) begin errors++; $display("FAIL walk_fwd_%0d: lat %0d key %h idx %0d want 1 %h %0d", s, n, a_key_state, a_round_idx, m_key, m_idx); end
            checks++; if (a_rk_data !== m_rk(m_key, 1'b0)) begin errors++; $display("FAIL walk_rk_%0d: got %h want %h", s, a_rk_data, m_rk(m_key, 1'b0)); end
            a_consume();
        end
        a_issue(2'b01, 1'b0, rand_key());
        checks++; if (a_err !== 1'b1 || a_rk_valid !== 1'b0 || a_key_state !== m_key) begin errors++; $display("FAIL walk_top_reject: err %0b valid %0b key %h want 1 0 %h", a_err, a_rk_valid, a_key_state, m_key); end
        @(posedge clk);
        #1;
        for (int s = 0; s < 40; s++) begin
            dir = 1'($urandom_range(0, 1));
            legal = dir ? (m_idx > 0) : (m_idx < A_ROUNDS - 1);
            a_issue(2'b01, dir, rand_key());
            if (legal) begin
                m_key = dir ? m_inv(m_key) : m_fwd(m_key);
                m_idx = dir ? m_idx - 1 : m_idx + 1;
                checks++; if (a_rk_valid !== 1'b1 || a_key_state !== m_key || a_round_idx !== 6'(m_idx)) begin errors++; $display("FAIL rand_step_%0d: valid %0b key %h idx %0d want 1 %h %0d", s, a_rk_valid, a_key_state, a_round_idx, m_key, m_idx); end
                a_consume();
            end else begin
                checks++; if (a_err !== 1'b1 || a_rk_valid !== 1'b0 || a_key_state !== m_key) begin errors++; $display("FAIL rand_reject_%0d: err %0b valid %0b want 1 0", s, a_err, a_rk_valid); end
                @(posedge clk);
                #1;
            end
        end
    endtask

`ifdef GIFT_KS_SEEK_EN
    task automatic test_seek();
        int n;
        int r;
        logic [127:0] k0;
        k0 = rand_key();
        a_issue(2'b00, 1'b0, k0);
        a_consume();
        m_key = k0;
        a_issue(2'b10, 1'b0, rand_key());
        a_wait_rk(n);
        for (int i = 0; i < A_ROUNDS - 1; i++) m_key = m_fwd(m_key);
        m_idx = A_ROUNDS - 1;
        checks++; if (n != 11) begin errors++; $display("FAIL seek_fwd_lat: got %0d want 11", n); end
        checks++; if (a_key_state !== m_key || a_round_idx !== 6'(m_idx)) begin errors++; $display("FAIL seek_fwd_state: key %h idx %0d want %h %0d", a_key_state, a_round_idx, m_key, m_idx); end
        checks++; if (a_rk_data !== m_rk(m_key, 1'b0)) begin errors++; $display("FAIL seek_fwd_rk: got %h want %h", a_rk_data, m_rk(m_key, 1'b0)); end
        a_consume();
        a_issue(2'b10, 1'b1, rand_key());
        a_wait_rk(n);
        m_key = k0;
        m_idx = 0;
        checks++; if (n != 11) begin errors++; $display("FAIL seek_inv_lat: got %0d want 11", n); end
        checks++; if (a_key_state !== k0 || a_round_idx !== 6'd0) begin errors++; $display("FAIL seek_inv_state: key %h idx %0d want %h 0", a_key_state, a_round_idx, k0); end
        for (int c = 0; c < 5; c++) begin
            a_cmd_valid = 1'b1;
            a_cmd_op    = 2'b00;
            @(posedge clk);
            #1;
            checks++; if (a_rk_valid !== 1'b1 || a_cmd_ready !== 1'b0 || a_key_state !== k0 || a_round_idx !== 6'd0 || a_rk_data !== m_rk(k0, 1'b0)) begin errors++; $display("FAIL seek_hold_%0d: valid %0b ready %0b key %h rk %h", c, a_rk_valid, a_cmd_ready, a_key_state, a_rk_data); end
        end
        a_cmd_valid = 1'b0;
        a_consume();
        for (int s = 0; s < 5; s++) begin
            a_issue(2'b01, 1'b0, rand_key());
            m_key = m_fwd(m_key);
            m_idx++;
            a_consume();
        end
        for (int t = 0; t < 3; t++) begin
            r = (t == 2) ? m_idx : (A_ROUNDS - 1 - m_idx);
            a_issue(2'b10, (t == 2), rand_key());
            a_wait_rk(n);
            for (int i = 0; i < r; i++) m_key = (t == 2) ? m_inv(m_key) : m_fwd(m_key);
            m_idx = (t == 2) ? 0 : A_ROUNDS - 1;
            checks++; if (n != 1 + (r + A_UNROLL - 1) / A_UNROLL) begin errors++; $display("FAIL seek_lat_%0d: got %0d want %0d", t, n, 1 + (r + A_UNROLL - 1) / A_UNROLL); end
            checks++; if (a_key_state !== m_key || a_round_idx !== 6'(m_idx)) begin errors++; $display("FAIL seek_state_%0d: key %h idx %0d want %h %0d", t, a_key_state, a_round_idx, m_key, m_idx); end
            a_consume();
        end
    endtask

    task automatic test_reset_busy();
        a_issue(2'b00, 1'b0, rand_key());
        a_consume();
        a_issue(2'b10, 1'b0, rand_key());
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checks++; if (a_rk_valid !== 1'b0 || a_cmd_ready !== 1'b0) begin errors++; $display("FAIL busy_state: valid %0b ready %0b want 0 0", a_rk_valid, a_cmd_ready); end
        rst = 1'b1;
        #1;
        checks++; if (a_cmd_ready !== 1'b1 || a_rk_valid !== 1'b0 || a_err !== 1'b0 || a_rk_data !== 64'h0 || a_round_idx !== 6'd0 || a_key_state !== 128'h0) begin errors++; $display("FAIL busy_reset: ready %0b valid %0b rk %h idx %0d key %h", a_cmd_ready, a_rk_valid, a_rk_data, a_round_idx, a_key_state); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (a_cmd_ready !== 1'b1 || a_rk_valid !== 1'b0) begin errors++; $display("FAIL busy_after_reset: ready %0b valid %0b", a_cmd_ready, a_rk_valid); end
        m_key = '0;
        m_idx = 0;
    endtask
`else
    task automatic test_seek();
        for (int d = 0; d < 2; d++) begin
            a_issue(2'b10, 1'(d), rand_key());
            checks++; if (a_err !== 1'b1 || a_rk_valid !== 1'b0 || a_key_state !== m_key || a_round_idx !== 6'(m_idx)) begin errors++; $display("FAIL seek_reject_%0d: err %0b valid %0b key %h", d, a_err, a_rk_valid, a_key_state); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_busy();
        a_issue(2'b00, 1'b0, rand_key());
        checks++; if (a_rk_valid !== 1'b1) begin errors++; $display("FAIL out_state: valid %0b want 1", a_rk_valid); end
        rst = 1'b1;
        #1;
        checks++; if (a_cmd_ready !== 1'b1 || a_rk_valid !== 1'b0 || a_err !== 1'b0 || a_rk_data !== 64'h0 || a_round_idx !== 6'd0 || a_key_state !== 128'h0) begin errors++; $display("FAIL out_reset: ready %0b valid %0b rk %h key %h", a_cmd_ready, a_rk_valid, a_rk_data, a_key_state); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        m_key = '0;
        m_idx = 0;
    endtask
`endif

    task automatic test_gift64();
        logic [127:0] k;
        b_rk_ready = 1'b1;
        b_issue(2'b00, 1'b0, 128'h1);
        checks++; if (b_rk_valid !== 1'b1 || b_rk_data !== 64'h1) begin errors++; $display("FAIL g64_load: valid %0b rk %h want 1 1", b_rk_valid, b_rk_data); end
        @(posedge clk);
        #1;
        b_rk_ready = 1'b0;
        k = rand_key();
        b_issue(2'b00, 1'b0, k);
        checks++; if (b_rk_data !== m_rk(k, 1'b1)) begin errors++; $display("FAIL g64_load_rand: got %h want %h", b_rk_data, m_rk(k, 1'b1)); end
        b_consume();
        for (int s = 0; s < B_ROUNDS - 1; s++) begin
            b_issue(2'b01, 1'b0, rand_key());
            k = m_fwd(k);
            checks++; if (b_rk_valid !== 1'b1 || b_rk_data !== m_rk(k, 1'b1) || b_round_idx !== 6'(s + 1)) begin errors++; $display("FAIL g64_step_%0d: rk %h idx %0d want %h %0d", s, b_rk_data, b_round_idx, m_rk(k, 1'b1), s + 1); end
            b_consume();
        end
        b_issue(2'b01, 1'b0, rand_key());
        checks++; if (b_err !== 1'b1 || b_rk_valid !== 1'b0 || b_key_state !== k) begin errors++; $display("FAIL g64_top_reject: err %0b valid %0b", b_err, b_rk_valid); end
        @(posedge clk);
        #1;
        b_issue(2'b01, 1'b1, rand_key());
        k = m_inv(k);
        checks++; if (b_key_state !== k || b_round_idx !== 6'(B_ROUNDS - 2)) begin errors++; $display("FAIL g64_inv: key %h idx %0d want %h %0d", b_key_state, b_round_idx, k, B_ROUNDS - 2); end
        b_consume();
    endtask

    initial begin
        rst = 1'b1;
        a_cmd_valid = 1'b0; a_cmd_op = 2'b00; a_cmd_dir = 1'b0; a_key_in = '0; a_rk_ready = 1'b0;
        b_cmd_valid = 1'b0; b_cmd_op = 2'b00; b_cmd_dir = 1'b0; b_key_in = '0; b_rk_ready = 1'b0;
        test_reset();
        test_load();
        test_step();
        test_reject();
        test_walk();
        test_seek();
        test_reset_busy();
        test_gift64();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gift_keysch_engine.md
# gift_keysch_engine

Sequential, parametrised GIFT key-schedule engine for the pipelined GIFT datapath. It holds the 128-bit key state and steps it one or more rounds forward (encryption order) or backward (decryption order) per command. It can seek to the first or last round key in `UNROLL` rounds per cycle and emits the extracted round key over a valid/ready handshake. It replaces the single-step combinational inverse key update with one block that serves both cipher directions and both GIFT variants.

## Interface
- `ROUNDS`, 40, rounds in the schedule (28 for GIFT-64); `round_idx` spans 0..ROUNDS-1.
- `UNROLL`, 1, key-update steps per cycle during SEEK; legal 1..8.
- `GIFT64`, 0, 1 = GIFT-64 round-key extraction, 0 = GIFT-128.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: engine accepts a command.
- `cmd_op` in 2: 00 LOAD, 01 STEP, 10 SEEK, 11 reserved.
- `cmd_dir` in 1: 0 forward, 1 inverse; ignored for LOAD.
- `key_in` in 128: master key, sampled on LOAD accept.
- `rk_valid` out 1: round key available.
- `rk_ready` in 1: consumer takes the round key.
- `rk_data` out 64: {U,V}; GIFT-128: U=k5‖k4, V=k1‖k0; GIFT-64: {32'h0, k1, k0}.
- `round_idx` out 6: round index of the current key state.
- `key_state` out 128: current state k7..k0, with k7 = [127:112].
- `err` out 1: one-cycle pulse on a rejected command.

## Operation
- Forward step: k7..k0 ← (k1 ⋙ 2)‖(k0 ⋙ 12)‖k7‖…‖k2.
- Inverse step: [127:32] ← [95:0]; [31:16] ← [127:112] ⋘ 2; [15:0] ← [111:96] ⋘ 12. The inverse step is the exact inverse of the forward step.
- FSM states are IDLE, BUSY and OUT. `cmd_ready` = (state == IDLE).
- LOAD: key ← `key_in`, `round_idx` ← 0, then IDLE→OUT.
- STEP forward:
  - Legal when `round_idx` < ROUNDS-1. Applies one step, `round_idx`+1, IDLE→OUT.
  - At ROUNDS-1 the command is rejected: `err` pulse, no state change, stay IDLE.
- STEP inverse:
  - Legal when `round_idx` > 0. Applies one inverse step, `round_idx`−1, IDLE→OUT.
  - At 0 the command is rejected in the same way.
- SEEK: target is ROUNDS-1 (forward) or 0 (inverse).
  - Remaining distance r = 0 → IDLE→OUT directly.
  - Otherwise IDLE→BUSY. Each BUSY cycle applies min(UNROLL, r) steps, selected from the unrolled chain tap. `round_idx` is updated by the same count. BUSY→OUT when r reaches 0.
- OUT: `rk_valid`=1, `rk_data` extracted from the held state. OUT→IDLE on `rk_ready`.
- Reserved op, or SEEK with the macro absent: rejected.
- Rejected commands: accepted for one cycle, `err`=1 in the next cycle, key and `round_idx` unchanged, no `rk_valid`.

## Timing
- Reset values:
  - state IDLE, key 0, `round_idx` 0.
  - `rk_valid` 0, `err` 0, `cmd_ready` 1, `rk_data` 0.
- Command accepted at edge T:
  - LOAD/STEP: `rk_valid` high from T+1.
  - SEEK: `rk_valid` high from T+1+ceil(r/UNROLL).
- `rk_data`, `key_state` and `round_idx` are registered and stable while `rk_valid` is high without `rk_ready`.
- `rk_ready` in the first OUT cycle → `cmd_ready` high in the next cycle; there is no back-to-back overlap.
- `rst` during BUSY or OUT aborts immediately: all outputs return to reset values, and the key state is lost.
- `cmd_valid` during BUSY/OUT is ignored (`cmd_ready`=0). The issuer must hold `cmd_op`, `cmd_dir` and `key_in` stable until accepted.

## Configuration
- `GIFT_KS_SEEK_EN` defined: SEEK op and the UNROLL-wide step chains are compiled in.
- Absent:
  - Only single forward and inverse step logic exists.
  - `UNROLL` is ignored and the BUSY state is removed.
  - `cmd_op`=10 is rejected with `err`.

## Structure
- Package `gift_ks_pkg`:
  - op-code constants;
  - FSM state enum;
  - round-key extraction function for GIFT-64/128;
  - forward/inverse word-rotation amounts (2, 12).
- Sub-module `gift_ks_step`: combinational single step with a `dir` input. It is instantiated UNROLL times in a chain; tap i feeds the SEEK mux.

## Test plan
- LOAD key 128'h1, `rk_ready`=1 → `rk_valid` at T+1, `rk_data`=64'h1, `round_idx`=0.
- STEP forward after that LOAD → `key_state`=128'h0000_0010_0000_0000_0000_0000_0000_0000, `round_idx`=1. Then STEP inverse → `key_state`=128'h1, `round_idx`=0.
- STEP inverse at `round_idx`=0 → `err` pulse, no `rk_valid`, `key_state` unchanged.
- ROUNDS=40, UNROLL=4, SEEK forward from 0 → `rk_valid` at T+11 (10 BUSY cycles), `round_idx`=39. State equals 39 single forward steps from a reference model.
- SEEK inverse from 39 → original key restored, `round_idx`=0. `rk_ready` held low for 5 cycles → outputs stable, `cmd_ready`=0 throughout.
- `rst` asserted in the 3rd BUSY cycle → all outputs at reset values in the same cycle; GIFT64=1 build: LOAD 128'h1 → `rk_data`=64'h1.
